// File: rtl/fpu_issue.sv
// Issue queue in front of a fixed-latency FPU: operation FIFO, credit-gated issue,
// in-flight tracking shift register and an in-order result FIFO.
module fpu_issue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic [1:0]       fpu_opcode,
    input  logic [31:0]      fpu_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + LATENCY) + 1;

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } res_t;

    op_t  op_mem  [DEPTH];
    res_t res_mem [DEPTH];
    logic [TAG_W-1:0] tag_q [LATENCY];

    logic [PTR_W-1:0]   op_wr_q, op_wr_d, op_rd_q, op_rd_d;
    logic [PTR_W-1:0]   res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [31:0]        fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
    logic [1:0]         fpu_op_q, fpu_op_d;

    logic             op_empty, op_full, res_empty, res_full;
    logic             push, issue, res_push, pop, credit;
    logic [CNT_W-1:0] res_cnt, inflight_cnt;
    op_t              op_head;
    res_t             res_head;

    // FIFO status: full is "same index, different wrap bit".
    always_comb begin
        op_empty  = (op_wr_q == op_rd_q);
        op_full   = (op_wr_q[IDX_W-1:0] == op_rd_q[IDX_W-1:0]) && (op_wr_q[IDX_W] != op_rd_q[IDX_W]);
        res_empty = (res_wr_q == res_rd_q);
        res_full  = (res_wr_q[IDX_W-1:0] == res_rd_q[IDX_W-1:0]) && (res_wr_q[IDX_W] != res_rd_q[IDX_W]);
        res_cnt   = CNT_W'(PTR_W'(res_wr_q - res_rd_q));
    end

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < int'(LATENCY); i++) begin
            inflight_cnt = inflight_cnt + CNT_W'(vld_q[i]);
        end
    end

    // Credits cover both queued and in-flight results so the result FIFO cannot overflow.
    always_comb begin
        op_head  = op_mem[op_rd_q[IDX_W-1:0]];
        res_head = res_mem[res_rd_q[IDX_W-1:0]];
        credit   = (res_cnt + inflight_cnt) < CNT_W'(DEPTH);
        in_ready = !op_full;
        push     = in_valid && !op_full;
        issue    = !op_empty && credit;
        res_push = vld_q[LATENCY-1];
        out_valid = !res_empty;
        pop      = out_valid && out_ready;
        out_data = res_empty ? '0 : res_head.data;
        out_tag  = res_empty ? '0 : res_head.tag;
    end

    always_comb begin
        op_wr_d  = op_wr_q + PTR_W'(push);
        op_rd_d  = op_rd_q + PTR_W'(issue);
        res_wr_d = res_wr_q + PTR_W'(res_push);
        res_rd_d = res_rd_q + PTR_W'(pop);
        vld_d    = '0;
        vld_d[0] = issue;
        for (int i = 1; i < int'(LATENCY); i++) begin
            vld_d[i] = vld_q[i-1];
        end
        fpu_a_d  = fpu_a_q;
        fpu_b_d  = fpu_b_q;
        fpu_op_d = fpu_op_q;
        if (issue) begin
            fpu_a_d  = op_head.a;
            fpu_b_d  = op_head.b;
            fpu_op_d = op_head.op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_wr_q  <= '0;
            op_rd_q  <= '0;
            res_wr_q <= '0;
            res_rd_q <= '0;
            vld_q    <= '0;
            fpu_a_q  <= '0;
            fpu_b_q  <= '0;
            fpu_op_q <= '0;
        end else begin
            op_wr_q  <= op_wr_d;
            op_rd_q  <= op_rd_d;
            res_wr_q <= res_wr_d;
            res_rd_q <= res_rd_d;
            vld_q    <= vld_d;
            fpu_a_q  <= fpu_a_d;
            fpu_b_q  <= fpu_b_d;
            fpu_op_q <= fpu_op_d;
        end
    end

    // Storage needs no reset: pointers and valid bits qualify every entry.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[op_wr_q[IDX_W-1:0]] <= '{a: in_a, b: in_b, op: in_op, tag: in_tag};
        end
        if (res_push) begin
            res_mem[res_wr_q[IDX_W-1:0]] <= '{data: fpu_o, tag: tag_q[LATENCY-1]};
        end
        tag_q[0] <= op_head.tag;
        for (int i = 1; i < int'(LATENCY); i++) begin
            tag_q[i] <= tag_q[i-1];
        end
    end

    assign fpu_a      = fpu_a_q;
    assign fpu_b      = fpu_b_q;
    assign fpu_opcode = fpu_op_q;

    res_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(res_push && res_full));

endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue with a fixed-latency FPU stand-in.
module tb_fpu_issue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned LATENCY = 3;
    localparam int unsigned TAG_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = '0, in_b = '0;
    logic [1:0]       in_op = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [31:0]      fpu_a, fpu_b, fpu_o;
    logic [1:0]       fpu_opcode;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    int checks = 0;
    int failures = 0;
    int acc, got;
    logic rdy;

    fpu_issue #(.DEPTH(DEPTH), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_o(fpu_o),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // FPU stand-in: exact for 1.0+2.0, a deterministic mix otherwise.
    function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && op == 2'd0) return 32'h4040_0000;
        return a + (b << 1) + 32'(op);
    endfunction

    // LATENCY-1 register stages: result of operands loaded at edge E is sampled at E+LATENCY.
    logic [31:0] p1 = '0, p2 = '0;
    always @(posedge clk) begin
        p1 <= fmodel(fpu_a, fpu_b, fpu_opcode);
        p2 <= p1;
    end
    assign fpu_o = p2;

    function automatic logic [31:0] exp_data(input logic [31:0] base, input int i);
        return fmodel(base + 32'(i), 32'h0100_0000 + 32'(i), 2'(i));
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] base, input int i);
        in_valid = v;
        in_a     = base + 32'(i);
        in_b     = 32'h0100_0000 + 32'(i);
        in_op    = 2'(i);
        in_tag   = TAG_W'(i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_fpu_a", fpu_a, 32'd0);
        chk("rst_fpu_b", fpu_b, 32'd0);
        chk("rst_fpu_op", 32'(fpu_opcode), 32'd0);
        step();
        rst_n = 1'b1;

        // Single op, minimum latency.
        in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h4000_0000; in_op = 2'd0; in_tag = 4'd5;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_e0_valid", 32'(out_valid), 32'd0);
        step();
        chk("t1_issue_a", fpu_a, 32'h3F80_0000);
        chk("t1_issue_b", fpu_b, 32'h4000_0000);
        chk("t1_issue_op", 32'(fpu_opcode), 32'd0);
        step();
        step();
        chk("t1_e3_valid", 32'(out_valid), 32'd0);
        step();
        chk("t1_e4_valid", 32'(out_valid), 32'd1);
        chk("t1_e4_data", out_data, 32'h4040_0000);
        chk("t1_e4_tag", 32'(out_tag), 32'd5);
        step();
        chk("t1_e5_valid", 32'(out_valid), 32'd0);

        // Back-to-back: four ops, consecutive issues and results.
        for (int k = 0; k < 9; k++) begin
            drive(k < 4, 32'h100, k);
            step();
            if (k >= 1 && k <= 4) chk("t2_issue_a", fpu_a, 32'h100 + 32'(k - 1));
            if (k >= 4 && k <= 7) begin
                chk("t2_valid", 32'(out_valid), 32'd1);
                chk("t2_tag", 32'(out_tag), 32'(k - 4));
                chk("t2_data", out_data, exp_data(32'h100, k - 4));
            end
            if (k == 8) chk("t2_empty", 32'(out_valid), 32'd0);
        end

        // Backpressure: ten ops offered with the consumer stalled.
        out_ready = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            drive(acc < 10, 32'h300, acc);
            rdy = in_ready;
            step();
            if (rdy && in_valid) acc++;
        end
        chk("t3_accepted", 32'(acc), 32'd8);
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        chk("t3_last_issue", fpu_a, 32'h303);
        chk("t3_head_tag", 32'(out_tag), 32'd0);
        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 60 && (got < 10 || acc < 10); cyc++) begin
            drive(acc < 10, 32'h300, acc);
            if (out_valid) begin
                chk("t3_tag", 32'(out_tag), 32'(got));
                chk("t3_data", out_data, exp_data(32'h300, got));
                got++;
            end
            rdy = in_ready;
            step();
            if (rdy && in_valid) acc++;
        end
        drive(1'b0, 32'h0, 0);
        chk("t3_got", 32'(got), 32'd10);
        chk("t3_acc_all", 32'(acc), 32'd10);
        for (int i = 0; i < 5; i++) step();
        chk("t3_drained", 32'(out_valid), 32'd0);

        // Credit boundary: three results held, nothing in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h400, k);
            step();
        end
        drive(1'b0, 32'h400, 0);
        for (int i = 0; i < 6; i++) step();
        chk("t4_held", 32'(out_valid), 32'd1);
        drive(1'b1, 32'h500, 0);
        step();
        drive(1'b1, 32'h500, 1);
        step();
        drive(1'b0, 32'h500, 0);
        chk("t4_first_issue", fpu_a, 32'h500);
        for (int i = 0; i < 5; i++) step();
        chk("t4_stall", fpu_a, 32'h500);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_pop_edge", fpu_a, 32'h500);
        step();
        chk("t4_one_more", fpu_a, 32'h501);
        for (int i = 0; i < 4; i++) step();
        chk("t4_head", 32'(out_tag), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("t4_drained", 32'(out_valid), 32'd0);

        // Reset with two ops in flight and one result queued.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h700, k);
            step();
        end
        drive(1'b0, 32'h700, 0);
        step();
        step();
        chk("t5_pre", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(out_valid), 32'd0);
        chk("t5_async_ready", 32'(in_ready), 32'd1);
        chk("t5_async_fpu_a", fpu_a, 32'd0);
        chk("t5_async_data", out_data, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_post_valid", 32'(out_valid), 32'd0);
        end
        chk("t5_post_fpu_a", fpu_a, 32'd0);

        // Simultaneous events: full opfifo with issue and offer; result write with pop.
        acc = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            drive(acc < 9, 32'h600, acc);
            rdy = in_ready;
            step();
            if (rdy && in_valid) acc++;
        end
        chk("t6_accepted", 32'(acc), 32'd8);
        chk("t6_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        rdy = in_ready;
        step();
        if (rdy && in_valid) acc++;
        out_ready = 1'b0;
        chk("t6_q0_noissue", fpu_a, 32'h603);
        chk("t6_q0_tag", 32'(out_tag), 32'd1);
        chk("t6_q0_ready", 32'(in_ready), 32'd0);
        rdy = in_ready;
        step();
        if (rdy && in_valid) acc++;
        chk("t6_push_refused", 32'(acc), 32'd8);
        chk("t6_issue", fpu_a, 32'h604);
        chk("t6_ready_rises", 32'(in_ready), 32'd1);
        drive(1'b0, 32'h600, 0);
        step();
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t6_wr_pop_valid", 32'(out_valid), 32'd1);
        chk("t6_wr_pop_tag", 32'(out_tag), 32'd2);
        step();
        chk("t6_count_kept", fpu_a, 32'h605);
        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            if (out_valid) begin
                chk("t6_tag", 32'(out_tag), 32'(got + 2));
                chk("t6_data", out_data, exp_data(32'h600, got + 2));
                got++;
            end
            step();
        end
        chk("t6_got", 32'(got), 32'd6);
        for (int i = 0; i < 3; i++) step();
        chk("t6_drained", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_issue.md
FPU_ISSUE -- requirements
Module: fpu_issue

Interface
Parameters (name, default, meaning):
REQ-001 DEPTH, 4, entries in the operation FIFO and in the result FIFO (power of two, >= 2).
REQ-002 LATENCY, 3, clock edges from the FPU operand update to the FPU result being sampled.
REQ-003 TAG_W, 4, width of the caller tag carried with each operation.

Ports (name, direction, width, meaning):
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  operation request.
REQ-007 in_ready  out  1  operation FIFO not full.
REQ-008 in_a, in_b  in  32  IEEE-754 single operands.
REQ-009 in_op  in  2  operation code: 0 add, 1 sub, 2 mul, 3 div.
REQ-010 in_tag  in  TAG_W  caller tag.
REQ-011 fpu_a, fpu_b  out  32  registered operands to the FPU A and B inputs.
REQ-012 fpu_opcode  out  2  registered opcode to the FPU.
REQ-013 fpu_o  in  32  FPU result output O.
REQ-014 out_valid  out  1  result FIFO not empty.
REQ-015 out_ready  in  1  consumer accepts the result.
REQ-016 out_data  out  32  result at the head of the result FIFO.
REQ-017 out_tag  out  TAG_W  tag at the head of the result FIFO.

Function
REQ-018 An operation is accepted at a rising edge when in_valid && in_ready; {a, b, op, tag} is written to the operation FIFO.
REQ-019 in_ready SHALL be the combinational value !opfifo_full. There is no bypass, so a push into a full FIFO is never accepted, even when an issue occurs on the same edge.
REQ-020 Issue condition, evaluated on every edge: opfifo not empty && (resfifo_count + inflight_count) < DEPTH.
REQ-021 On an issue edge, the head entry is popped and fpu_a, fpu_b and fpu_opcode are loaded from it. These outputs hold their values until the next issue.
REQ-022 Each issue shifts a valid bit plus the tag into a LATENCY-deep in-flight shift register. Non-issue edges shift in a 0 valid bit.
REQ-023 When the valid bit exits the shift register (edge issue+LATENCY), fpu_o and the tag are written to the result FIFO on that edge.
REQ-024 inflight_count SHALL equal the number of set valid bits in the shift register.
REQ-025 Throughput SHALL be at most one issue per clock. A stalled consumer blocks issue only through the credit rule (REQ-020).
REQ-026 The credit rule guarantees the result FIFO never overflows. A result write into a full FIFO is a design error and SHALL be asserted against in simulation.
REQ-027 A result is popped when out_valid && out_ready. out_data and out_tag SHALL present the FIFO head combinationally.
REQ-028 A simultaneous result write and pop SHALL leave the result count unchanged. A simultaneous push and issue SHALL leave the operation count unchanged.
REQ-029 Results SHALL leave in issue order, and issue order SHALL equal acceptance order.
REQ-030 FIFO pointers SHALL be log2(DEPTH)+1 bits. Full is the condition "same index, different wrap bit"; pointers wrap modulo 2*DEPTH.
REQ-031 Minimum latency from an acceptance edge E0 to out_valid high is 4 edges (issue at E0+1, result written at E0+1+LATENCY).

Reset
REQ-032 While rst_n is low, the following SHALL be forced immediately (asynchronously) to their reset values:
- both FIFOs empty; in_ready=1, out_valid=0;
- out_data=0, out_tag=0;
- in-flight valid bits=0;
- fpu_a=0, fpu_b=0, fpu_opcode=0.
REQ-033 Reset mid-operation SHALL discard all queued and in-flight operations. fpu_o values that arrive after reset deassertion for pre-reset issues SHALL never be written to the result FIFO.
REQ-034 The first acceptance is permitted on the first rising edge after rst_n goes high.

Verification
REQ-035 Single op: push a=0x3F800000, b=0x40000000, op=0, tag=5, with out_ready=1. Required: out_valid rises 4 edges after acceptance, with out_data=0x40400000 and out_tag=5, for exactly one cycle.
REQ-036 Back-to-back: push 4 ops with tags 0..3 on consecutive edges, out_ready=1. Required: issues on 4 consecutive edges, and results appear in tag order 0,1,2,3 on consecutive cycles.
REQ-037 Backpressure: out_ready=0, offer 10 ops. Required:
- exactly 4 issues occur;
- in_ready drops after 8 acceptances;
- no further issue while 4 results are held.
Then raise out_ready. Required: all 8 results emerge in order, and the remaining 2 ops are then accepted.
REQ-038 Credit boundary: result FIFO holding 3 entries, 0 in flight, out_ready=0. Required: exactly 1 issue, then issue stalls; one pop permits exactly one further issue on the following edge.
REQ-039 Reset mid-flight: assert rst_n=0 for 1 cycle with 2 ops in flight and 1 result queued. Required: out_valid=0 immediately, and no out_valid for 5 cycles after release with no new pushes.
REQ-040 Simultaneous events: opfifo full, with issue and an in_valid offer on the same edge. Required: the push is refused and in_ready rises the next cycle; a result write with a pop on the same edge keeps out_valid high and the count unchanged.
